// File: rtl/multicycle_cu.sv
// Multicycle RISC-V control unit: Moore state decode with a Mealy branch strobe,
// a sticky illegal-instruction flag and a retired-instruction counter.
module multicycle_cu #(
  parameter int ALUC_W     = 3,
  parameter int ENABLE_LUI = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic              zero,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              AdrSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [2:0]        ImmSrc,
  output logic              illegal,
  output logic [CNT_W-1:0]  instret,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  state_t             state_q, state_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic               exec_ok;
  logic [2:0]         exec_alu;
  logic               br_ok;
  logic               br_take;
  logic [2:0]         br_alu;
  logic [2:0]         alu_op;

  // R/I arithmetic decode; only R-type constrains func7.
  always_comb begin
    exec_ok  = 1'b1;
    exec_alu = ALU_ADD;
    case (func3)
      3'b000:  exec_alu = (state_q == S_EXECR && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  exec_alu = ALU_SLT;
      3'b110:  exec_alu = ALU_OR;
      3'b111:  exec_alu = ALU_AND;
      default: exec_ok  = 1'b0;
    endcase
    if (state_q == S_EXECR && func7 != 7'b0000000 && func7 != 7'b0100000) begin
      exec_ok = 1'b0;
    end
    if (!exec_ok) begin
      exec_alu = ALU_ADD;
    end
  end

  // blt/bge reuse slt, so the zero flag means "not less than" for them.
  always_comb begin
    br_ok   = 1'b1;
    br_take = 1'b0;
    br_alu  = ALU_ADD;
    case (func3)
      3'b000: begin br_alu = ALU_SUB; br_take = zero;  end
      3'b001: begin br_alu = ALU_SUB; br_take = ~zero; end
      3'b100: begin br_alu = ALU_SLT; br_take = ~zero; end
      3'b101: begin br_alu = ALU_SLT; br_take = zero;  end
      default: br_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = (ENABLE_LUI != 0) ? S_LUI : S_HALT;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = exec_ok ? S_ALUWB : S_HALT;
      S_EXECI:    state_d = exec_ok ? S_ALUWB : S_HALT;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = br_ok ? S_FETCH : S_HALT;
      S_JAL:      state_d = S_FETCH;
      S_JALR:     state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
  end

  // Datapath controls decoded from the current state; IR-derived fields are
  // stable after FETCH so DECODE/MEMADR/ALUWB may look at opcode directly.
  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    alu_op    = ALU_ADD;
    ImmSrc    = IMM_I;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM;
        if (opcode == OP_JALR) begin
          ALUSrcA = SRCA_RD1;
          ImmSrc  = IMM_I;
        end else begin
          ALUSrcA = SRCA_OLDPC;
          ImmSrc  = IMM_B;
        end
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = exec_alu;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
        alu_op  = exec_alu;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        if (opcode == OP_JALR) begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
        end else begin
          ResultSrc = RES_ALUOUT;
        end
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        alu_op    = br_alu;
        PCWrite   = br_ok & br_take;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        ImmSrc    = IMM_J;
        PCWrite   = 1'b1;
        RegWrite  = 1'b1;
      end
      S_JALR: begin
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
      end
      S_LUI: begin
        ImmSrc    = IMM_U;
        ResultSrc = RES_IMM;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  // An instruction retires when the FSM comes back to FETCH; HALT never returns.
  always_comb begin
    illegal_d = illegal_q | (state_d == S_HALT);
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  assign ALUControl = ALUC_W'(alu_op);
  assign illegal    = illegal_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Random instruction stream against a per-instruction cycle-table model, plus
// directed runs on a narrow-counter, LUI-disabled instance.
module tb_multicycle_cu;

  localparam int RW = 22;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [4:0] PCW = 5'b10000;
  localparam logic [4:0] IRW = 5'b01000;
  localparam logic [4:0] MW  = 5'b00100;
  localparam logic [4:0] RGW = 5'b00010;
  localparam logic [4:0] ADR = 5'b00001;
  localparam logic [4:0] NON = 5'b00000;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011, SLT = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, s_rst;
  logic [6:0] opcode, func7, s_opcode, s_func7;
  logic [2:0] func3, s_func3;
  logic       zero, s_zero;

  logic        m_pcw, m_irw, m_mw, m_rw, m_adr, m_ill;
  logic [1:0]  m_sa, m_sb, m_rs;
  logic [2:0]  m_aluc, m_imm;
  logic [31:0] m_instret;
  logic [3:0]  m_state;

  logic        s_pcw, s_irw, s_mw, s_rw, s_adr, s_ill;
  logic [1:0]  s_sa, s_sb, s_rs;
  logic [4:0]  s_aluc;
  logic [2:0]  s_imm;
  logic [3:0]  s_instret;
  logic [3:0]  s_state;

  multicycle_cu u_main (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .zero(zero),
    .PCWrite(m_pcw), .IRWrite(m_irw), .MemWrite(m_mw), .RegWrite(m_rw), .AdrSrc(m_adr),
    .ALUSrcA(m_sa), .ALUSrcB(m_sb), .ResultSrc(m_rs), .ALUControl(m_aluc),
    .ImmSrc(m_imm), .illegal(m_ill), .instret(m_instret), .state(m_state)
  );

  multicycle_cu #(.ALUC_W(5), .ENABLE_LUI(0), .CNT_W(4)) u_small (
    .clk(clk), .rst(s_rst), .opcode(s_opcode), .func3(s_func3), .func7(s_func7), .zero(s_zero),
    .PCWrite(s_pcw), .IRWrite(s_irw), .MemWrite(s_mw), .RegWrite(s_rw), .AdrSrc(s_adr),
    .ALUSrcA(s_sa), .ALUSrcB(s_sb), .ResultSrc(s_rs), .ALUControl(s_aluc),
    .ImmSrc(s_imm), .illegal(s_ill), .instret(s_instret), .state(s_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];
  logic [31:0]   ret_m;
  logic [3:0]    ret_s;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Record layout: state, {PCW,IRW,MW,RW,ADR}, SrcA, SrcB, ResultSrc, ALU, Imm, illegal
  function automatic logic [RW-1:0] rec(input logic [3:0] st, input logic [4:0] strb,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] rs, input logic [2:0] alu,
                                        input logic [2:0] imm, input logic ill);
    return {st, strb, sa, sb, rs, alu, imm, ill};
  endfunction

  function automatic logic [RW-1:0] observe(input bit sel);
    if (sel)
      return {s_state, s_pcw, s_irw, s_mw, s_rw, s_adr, s_sa, s_sb, s_rs, s_aluc[2:0], s_imm, s_ill};
    return {m_state, m_pcw, m_irw, m_mw, m_rw, m_adr, m_sa, m_sb, m_rs, m_aluc, m_imm, m_ill};
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, from the instruction class.
  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input bit en_lui, output bit legal);
    logic [2:0] alu;
    logic       take;
    bit         ok;
    legal = 1'b1;
    exp_q.push_back(rec(4'd0, PCW | IRW, 2'b00, 2'b10, 2'b10, ADD, 3'b000, 1'b0));
    if (op == OP_JALR) exp_q.push_back(rec(4'd1, NON, 2'b10, 2'b01, 2'b00, ADD, 3'b000, 1'b0));
    else               exp_q.push_back(rec(4'd1, NON, 2'b01, 2'b01, 2'b00, ADD, 3'b010, 1'b0));
    case (op)
      OP_LW: begin
        exp_q.push_back(rec(4'd2, NON, 2'b10, 2'b01, 2'b00, ADD, 3'b000, 1'b0));
        exp_q.push_back(rec(4'd3, ADR, 2'b00, 2'b00, 2'b00, ADD, 3'b000, 1'b0));
        exp_q.push_back(rec(4'd4, RGW, 2'b00, 2'b00, 2'b01, ADD, 3'b000, 1'b0));
      end
      OP_SW: begin
        exp_q.push_back(rec(4'd2, NON, 2'b10, 2'b01, 2'b00, ADD, 3'b001, 1'b0));
        exp_q.push_back(rec(4'd5, MW | ADR, 2'b00, 2'b00, 2'b00, ADD, 3'b000, 1'b0));
      end
      OP_R, OP_I: begin
        ok = (f3 inside {3'd0, 3'd2, 3'd6, 3'd7}) && (op == OP_I || f7 == 7'h00 || f7 == 7'h20);
        case (f3)
          3'd0:    alu = (op == OP_R && f7 == 7'h20) ? SUB : ADD;
          3'd2:    alu = SLT;
          3'd6:    alu = OR_;
          default: alu = AND_;
        endcase
        if (!ok) alu = ADD;
        if (op == OP_R) exp_q.push_back(rec(4'd6, NON, 2'b10, 2'b00, 2'b00, alu, 3'b000, 1'b0));
        else            exp_q.push_back(rec(4'd7, NON, 2'b10, 2'b01, 2'b00, alu, 3'b000, 1'b0));
        if (ok) exp_q.push_back(rec(4'd8, RGW, 2'b00, 2'b00, 2'b00, ADD, 3'b000, 1'b0));
        else legal = 1'b0;
      end
      OP_BR: begin
        ok   = f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
        alu  = (f3 == 3'd4 || f3 == 3'd5) ? SLT : SUB;
        take = (f3 == 3'd0 || f3 == 3'd5) ? z : ~z;
        if (!ok) begin alu = ADD; take = 1'b0; legal = 1'b0; end
        exp_q.push_back(rec(4'd9, take ? PCW : NON, 2'b10, 2'b00, 2'b00, alu, 3'b000, 1'b0));
      end
      OP_JAL:
        exp_q.push_back(rec(4'd10, PCW | RGW, 2'b01, 2'b10, 2'b00, ADD, 3'b011, 1'b0));
      OP_JALR: begin
        exp_q.push_back(rec(4'd11, PCW, 2'b00, 2'b00, 2'b00, ADD, 3'b000, 1'b0));
        exp_q.push_back(rec(4'd8, RGW, 2'b01, 2'b10, 2'b10, ADD, 3'b000, 1'b0));
      end
      OP_LUI: begin
        if (en_lui) exp_q.push_back(rec(4'd12, RGW, 2'b00, 2'b00, 2'b11, ADD, 3'b100, 1'b0));
        else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) repeat (10) exp_q.push_back(rec(4'd15, NON, 2'b00, 2'b00, 2'b00, ADD, 3'b000, 1'b1));
  endtask

  // Entered and left at posedge+1 while the DUT sits in FETCH.
  task automatic run_instr(input bit sel, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input int max_cyc,
                           output bit legal);
    logic [RW-1:0] e;
    int n;
    n = 0;
    if (sel) begin s_opcode = op; s_func3 = f3; s_func7 = f7; s_zero = z; end
    else     begin opcode = op;   func3 = f3;   func7 = f7;   zero = z;   end
    model_instr(op, f3, f7, z, !sel, legal);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      if (n == 0) begin
        if (sel) check("instret", {60'd0, s_instret}, {60'd0, ret_s});
        else     check("instret", {32'd0, m_instret}, {32'd0, ret_m});
      end
      check($sformatf("st%0d_op%0h_f3%0d", e[21:18], op, f3), {42'd0, observe(sel)}, {42'd0, e});
      if (sel) check("aluc_hi", {62'd0, s_aluc[4:3]}, 64'd0);
      @(posedge clk);
      #1;
      n++;
      if (n == max_cyc) begin
        exp_q.delete();
        legal = 1'b0;
      end
    end
    if (legal) begin
      if (sel) ret_s = ret_s + 4'd1;
      else     ret_m = ret_m + 32'd1;
    end
  endtask

  // Asynchronous pulse well away from both clock edges.
  task automatic do_reset(input bit sel);
    if (sel) s_rst = 1'b1; else rst = 1'b1;
    #1;
    if (sel) begin
      check("rst_state",   {60'd0, s_state},   64'd0);
      check("rst_illegal", {63'd0, s_ill},     64'd0);
      check("rst_instret", {60'd0, s_instret}, 64'd0);
      ret_s = '0;
    end else begin
      check("rst_state",   {60'd0, m_state},   64'd0);
      check("rst_illegal", {63'd0, m_ill},     64'd0);
      check("rst_instret", {32'd0, m_instret}, 64'd0);
      ret_m = '0;
    end
    #1;
    if (sel) s_rst = 1'b0; else rst = 1'b0;
  endtask

  function automatic logic [6:0] pick_op(input int k);
    logic [6:0] op;
    case (k)
      0: op = OP_LW;   1: op = OP_SW;  2, 3: op = OP_R;  4, 5: op = OP_I;
      6, 7: op = OP_BR; 8: op = OP_JAL; 9: op = OP_JALR; 10: op = OP_LUI;
      default: begin
        op = 7'($urandom_range(0, 127));
        while (op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI})
          op = 7'($urandom_range(0, 127));
      end
    endcase
    return op;
  endfunction

  initial begin
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit legal;
    rst = 1'b1; s_rst = 1'b1;
    opcode = '0; func3 = '0; func7 = '0; zero = 1'b0;
    s_opcode = '0; s_func3 = '0; s_func7 = '0; s_zero = 1'b0;
    ret_m = '0; ret_s = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Directed: add, lw, sw, beq taken, bge not taken, fence-like opcode.
    run_instr(1'b0, OP_R,  3'd0, 7'h00, 1'b0, 0, legal);
    run_instr(1'b0, OP_LW, 3'd2, 7'h00, 1'b0, 0, legal);
    run_instr(1'b0, OP_SW, 3'd2, 7'h00, 1'b0, 0, legal);
    run_instr(1'b0, OP_BR, 3'd0, 7'h00, 1'b1, 0, legal);
    run_instr(1'b0, OP_BR, 3'd5, 7'h00, 1'b0, 0, legal);
    run_instr(1'b0, 7'b0001111, 3'd0, 7'h00, 1'b0, 0, legal);
    do_reset(1'b0);

    for (int i = 0; i < 80; i++) begin
      op = pick_op($urandom_range(0, 12));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      run_instr(1'b0, op, f3, f7, 1'($urandom_range(0, 1)), 0, legal);
      if (!legal) do_reset(1'b0);
    end

    // Narrow instance: counter wrap, mid-EXECI reset, LUI disabled.
    do_reset(1'b1);
    for (int i = 0; i < 19; i++)
      run_instr(1'b1, OP_I, 3'd0, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 0, legal);
    run_instr(1'b1, OP_I, 3'd0, 7'h00, 1'b0, 2, legal);
    check("pre_rst_execi", {60'd0, s_state}, 64'd7);
    do_reset(1'b1);
    run_instr(1'b1, OP_LUI, 3'd0, 7'h00, 1'b0, 0, legal);
    do_reset(1'b1);
    run_instr(1'b1, OP_LW, 3'd2, 7'h00, 1'b0, 0, legal);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
